// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller of the 16-bit pipelined CPU.
// Takes one EX/MEM instruction at a time. ALU-only instructions complete in
// one edge. Loads and stores run a req/ack access against data memory while
// the upstream pipeline is stalled. Produces a registered MEM/WB result bundle
// plus a one-cycle wb_valid strobe per instruction.
//
// Optional build macro: MEM_TIMEOUT_EN
//   When defined, an access that has no d_ack for TIMEOUT_CYCLES edges is
//   squashed: wb_valid pulses with RegWrite_out/is_wwd_out low, and mem_err
//   is set and stays set until reset. Without it ACCESS waits indefinitely
//   and mem_err is tied low.
//
// Ports:
//   clk, reset_n         clock (rising edge), async active-low reset
//   ex_*                 EX/MEM pipeline register fields (held while mem_stall)
//   mem_stall            high for the whole ACCESS state (combinational)
//   d_req/d_we/d_addr/d_wdata, d_rdata/d_ack   data-memory handshake
//   wb_valid + *_out     registered MEM/WB result bundle
//   mem_err              sticky access-timeout flag
module mem_stage_ctrl #(
    parameter int unsigned WORD_SIZE = 16
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic [WORD_SIZE-1:0] ex_alu_result,
    input  logic [WORD_SIZE-1:0] ex_store_data,
    input  logic [1:0]           ex_rd,
    input  logic                 ex_memtoreg,
    input  logic                 ex_regwrite,
    input  logic                 ex_is_wwd,
    output logic                 mem_stall,
    output logic                 d_req,
    output logic                 d_we,
    output logic [WORD_SIZE-1:0] d_addr,
    output logic [WORD_SIZE-1:0] d_wdata,
    input  logic [WORD_SIZE-1:0] d_rdata,
    input  logic                 d_ack,
    output logic                 wb_valid,
    output logic [WORD_SIZE-1:0] MemData_out,
    output logic [WORD_SIZE-1:0] ALU_Result_out,
    output logic [1:0]           rd_out,
    output logic                 MemtoReg_out,
    output logic                 RegWrite_out,
    output logic                 is_wwd_out,
    output logic                 mem_err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0] state, state_d;

    // Fields of the instruction in flight, captured when the access starts
    logic       lat_read, lat_read_d;
    logic [1:0] lat_rd, lat_rd_d;
    logic       lat_memtoreg, lat_memtoreg_d;
    logic       lat_regwrite, lat_regwrite_d;
    logic       lat_is_wwd, lat_is_wwd_d;

    // Next values of the registered outputs
    logic                 d_req_d, d_we_d, wb_valid_d;
    logic [WORD_SIZE-1:0] d_addr_d, d_wdata_d, mem_data_d, alu_result_d;
    logic [1:0]           rd_d;
    logic                 memtoreg_d, regwrite_d, is_wwd_d;

    logic timeout_c;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] wait_cnt;

    // Wait counter: zero on entry to ACCESS, counts edges without d_ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // A d_ack on the timeout edge takes priority over the timeout
    assign timeout_c = (state == ST_ACCESS) && !d_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_err <= 1'b0;
        end else if (timeout_c) begin
            mem_err <= 1'b1;
        end
    end
`else
    assign timeout_c = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Upstream holds EX/MEM for as long as an access is outstanding
    assign mem_stall = (state == ST_ACCESS);

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            d_req          <= 1'b0;
            d_we           <= 1'b0;
            d_addr         <= '0;
            d_wdata        <= '0;
            wb_valid       <= 1'b0;
            MemData_out    <= '0;
            ALU_Result_out <= '0;
            rd_out         <= '0;
            MemtoReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            is_wwd_out     <= 1'b0;
            lat_read       <= 1'b0;
            lat_rd         <= '0;
            lat_memtoreg   <= 1'b0;
            lat_regwrite   <= 1'b0;
            lat_is_wwd     <= 1'b0;
        end else begin
            state          <= state_d;
            d_req          <= d_req_d;
            d_we           <= d_we_d;
            d_addr         <= d_addr_d;
            d_wdata        <= d_wdata_d;
            wb_valid       <= wb_valid_d;
            MemData_out    <= mem_data_d;
            ALU_Result_out <= alu_result_d;
            rd_out         <= rd_d;
            MemtoReg_out   <= memtoreg_d;
            RegWrite_out   <= regwrite_d;
            is_wwd_out     <= is_wwd_d;
            lat_read       <= lat_read_d;
            lat_rd         <= lat_rd_d;
            lat_memtoreg   <= lat_memtoreg_d;
            lat_regwrite   <= lat_regwrite_d;
            lat_is_wwd     <= lat_is_wwd_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        // Defaults: hold data, no result strobe, write enables low (bubble)
        state_d        = state;
        d_req_d        = d_req;
        d_we_d         = d_we;
        d_addr_d       = d_addr;
        d_wdata_d      = d_wdata;
        wb_valid_d     = 1'b0;
        mem_data_d     = MemData_out;
        alu_result_d   = ALU_Result_out;
        rd_d           = rd_out;
        memtoreg_d     = MemtoReg_out;
        regwrite_d     = 1'b0;
        is_wwd_d       = 1'b0;
        lat_read_d     = lat_read;
        lat_rd_d       = lat_rd;
        lat_memtoreg_d = lat_memtoreg;
        lat_regwrite_d = lat_regwrite;
        lat_is_wwd_d   = lat_is_wwd;

        case (state)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_read || ex_mem_write) begin
                        // Start an access; read+write together is a write
                        state_d        = ST_ACCESS;
                        d_req_d        = 1'b1;
                        d_we_d         = ex_mem_write;
                        d_addr_d       = ex_alu_result;
                        d_wdata_d      = ex_store_data;
                        lat_read_d     = ex_mem_read && !ex_mem_write;
                        lat_rd_d       = ex_rd;
                        lat_memtoreg_d = ex_memtoreg;
                        lat_regwrite_d = ex_regwrite;
                        lat_is_wwd_d   = ex_is_wwd;
                    end else begin
                        wb_valid_d   = 1'b1;
                        alu_result_d = ex_alu_result;
                        rd_d         = ex_rd;
                        memtoreg_d   = ex_memtoreg;
                        regwrite_d   = ex_regwrite;
                        is_wwd_d     = ex_is_wwd;
                    end
                end
            end
            ST_ACCESS: begin
                if (d_ack) begin
                    state_d      = ST_IDLE;
                    d_req_d      = 1'b0;
                    wb_valid_d   = 1'b1;
                    mem_data_d   = lat_read ? d_rdata : '0;
                    alu_result_d = d_addr;
                    rd_d         = lat_rd;
                    memtoreg_d   = lat_memtoreg;
                    regwrite_d   = lat_regwrite;
                    is_wwd_d     = lat_is_wwd;
                end else if (timeout_c) begin
                    // Squash: result slot is consumed but writes nothing
                    state_d      = ST_IDLE;
                    d_req_d      = 1'b0;
                    wb_valid_d   = 1'b1;
                    mem_data_d   = '0;
                    alu_result_d = d_addr;
                    rd_d         = lat_rd;
                    memtoreg_d   = lat_memtoreg;
                end
            end
            default: begin
                state_d = ST_IDLE;
                d_req_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (default build).
module tb_mem_stage_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         ex_valid, ex_mem_read, ex_mem_write;
    logic [W-1:0] ex_alu_result, ex_store_data;
    logic [1:0]   ex_rd;
    logic         ex_memtoreg, ex_regwrite, ex_is_wwd;
    logic         mem_stall, d_req, d_we;
    logic [W-1:0] d_addr, d_wdata, d_rdata;
    logic         d_ack;
    logic         wb_valid;
    logic [W-1:0] MemData_out, ALU_Result_out;
    logic [1:0]   rd_out;
    logic         MemtoReg_out, RegWrite_out, is_wwd_out, mem_err;

    int checks = 0;
    int errors = 0;
    int wb_pulses = 0;
    int pulse_base;

    mem_stage_ctrl #(.WORD_SIZE(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_is_wwd(ex_is_wwd),
        .mem_stall(mem_stall), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .wb_valid(wb_valid), .MemData_out(MemData_out), .ALU_Result_out(ALU_Result_out),
        .rd_out(rd_out), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .is_wwd_out(is_wwd_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Count result strobes, sampled away from the active edge
    always @(negedge clk) if (wb_valid === 1'b1) wb_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic rd_op, input logic wr_op,
                          input logic [W-1:0] alu, input logic [W-1:0] sd,
                          input logic [1:0] rd, input logic m2r, input logic rw);
        ex_valid      = v;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_memtoreg   = m2r;
        ex_regwrite   = rw;
        ex_is_wwd     = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);
        d_rdata = '0;
        d_ack   = 1'b0;
        #12;
        chk("rst_d_req", 32'(d_req), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        chk("rst_alu", 32'(ALU_Result_out), 32'h0);
        chk("rst_mem_err", 32'(mem_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU op: one-edge latency, no stall
        set_ex(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 2'd2, 1'b0, 1'b1);
        #1;
        chk("alu_stall_pre", 32'(mem_stall), 32'h0);
        tick();
        chk("alu_wb_valid", 32'(wb_valid), 32'h1);
        chk("alu_result", 32'(ALU_Result_out), 32'h1234);
        chk("alu_rd", 32'(rd_out), 32'h2);
        chk("alu_regwrite", 32'(RegWrite_out), 32'h1);
        chk("alu_stall", 32'(mem_stall), 32'h0);
        ex_valid = 1'b0;
        tick();
        chk("bubble_wb_valid", 32'(wb_valid), 32'h0);
        chk("bubble_regwrite", 32'(RegWrite_out), 32'h0);
        chk("bubble_alu_hold", 32'(ALU_Result_out), 32'h1234);

        // Load from 0x0040, ack on the third edge after accept
        pulse_base = wb_pulses;
        set_ex(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_d_req", 32'(d_req), 32'h1);
            chk("ld_d_addr", 32'(d_addr), 32'h0040);
            chk("ld_d_we", 32'(d_we), 32'h0);
            chk("ld_stall", 32'(mem_stall), 32'h1);
            chk("ld_wb_idle", 32'(wb_valid), 32'h0);
        end
        d_ack   = 1'b1;
        d_rdata = 16'hBEEF;
        tick();
        chk("ld_done_req", 32'(d_req), 32'h0);
        chk("ld_done_stall", 32'(mem_stall), 32'h0);
        chk("ld_done_wb", 32'(wb_valid), 32'h1);
        chk("ld_memdata", 32'(MemData_out), 32'hBEEF);
        chk("ld_memtoreg", 32'(MemtoReg_out), 32'h1);
        chk("ld_rd", 32'(rd_out), 32'h1);
        chk("ld_regwrite", 32'(RegWrite_out), 32'h1);
        ex_valid = 1'b0;
        d_ack    = 1'b0;
        tick();
        chk("ld_wb_pulse_end", 32'(wb_valid), 32'h0);
        chk("ld_pulse_count", 32'(wb_pulses - pulse_base), 32'd1);

        // Store 0x5A5A to 0x0010, zero-wait ack
        set_ex(1'b1, 1'b0, 1'b1, 16'h0010, 16'h5A5A, 2'd0, 1'b0, 1'b0);
        tick();
        chk("st_d_req", 32'(d_req), 32'h1);
        chk("st_d_we", 32'(d_we), 32'h1);
        chk("st_d_addr", 32'(d_addr), 32'h0010);
        chk("st_d_wdata", 32'(d_wdata), 32'h5A5A);
        d_ack   = 1'b1;
        d_rdata = 16'h7777;
        tick();
        chk("st_done_req", 32'(d_req), 32'h0);
        chk("st_done_wb", 32'(wb_valid), 32'h1);
        chk("st_regwrite", 32'(RegWrite_out), 32'h0);
        chk("st_memdata", 32'(MemData_out), 32'h0);
        ex_valid = 1'b0;
        d_ack    = 1'b0;
        tick();

        // Read and write together behave as a write; load data forced to 0
        set_ex(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1111, 2'd3, 1'b1, 1'b0);
        tick();
        chk("rw_d_we", 32'(d_we), 32'h1);
        chk("rw_d_wdata", 32'(d_wdata), 32'h1111);
        d_ack   = 1'b1;
        d_rdata = 16'hFFFF;
        tick();
        chk("rw_wb", 32'(wb_valid), 32'h1);
        chk("rw_memdata", 32'(MemData_out), 32'h0);
        ex_valid = 1'b0;
        d_ack    = 1'b0;
        tick();

        // d_ack while idle is ignored
        d_ack = 1'b1;
        tick();
        chk("idle_ack_wb", 32'(wb_valid), 32'h0);
        chk("idle_ack_stall", 32'(mem_stall), 32'h0);
        d_ack = 1'b0;

        // Async reset in the middle of an access
        set_ex(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000, 2'd1, 1'b1, 1'b1);
        tick();
        chk("mid_d_req", 32'(d_req), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_d_req", 32'(d_req), 32'h0);
        chk("async_stall", 32'(mem_stall), 32'h0);
        chk("async_d_addr", 32'(d_addr), 32'h0);
        chk("async_memdata", 32'(MemData_out), 32'h0);
        chk("async_memtoreg", 32'(MemtoReg_out), 32'h0);
        ex_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        d_ack   = 1'b1;
        d_rdata = 16'hDEAD;
        tick();
        chk("late_ack_wb", 32'(wb_valid), 32'h0);
        chk("late_ack_req", 32'(d_req), 32'h0);
        d_ack = 1'b0;
        tick();

        // Back-to-back: load, bubble, ALU op, bubble, load with one wait edge
        pulse_base = wb_pulses;
        set_ex(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'd1, 1'b1, 1'b1);
        tick();
        chk("b2b_l1_stall", 32'(mem_stall), 32'h1);
        d_ack   = 1'b1;
        d_rdata = 16'h0A0A;
        tick();
        chk("b2b_l1_wb", 32'(wb_valid), 32'h1);
        chk("b2b_l1_data", 32'(MemData_out), 32'h0A0A);
        ex_valid = 1'b0;
        d_ack    = 1'b0;
        tick();
        chk("b2b_gap1_rw", 32'(RegWrite_out), 32'h0);
        set_ex(1'b1, 1'b0, 1'b0, 16'h0777, 16'h0000, 2'd2, 1'b0, 1'b1);
        tick();
        chk("b2b_alu_wb", 32'(wb_valid), 32'h1);
        chk("b2b_alu_res", 32'(ALU_Result_out), 32'h0777);
        chk("b2b_alu_rd", 32'(rd_out), 32'h2);
        ex_valid = 1'b0;
        tick();
        chk("b2b_gap2_rw", 32'(RegWrite_out), 32'h0);
        set_ex(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'd3, 1'b1, 1'b1);
        tick();
        chk("b2b_l2_req", 32'(d_req), 32'h1);
        tick();
        chk("b2b_l2_wait", 32'(wb_valid), 32'h0);
        chk("b2b_l2_addr", 32'(d_addr), 32'h0200);
        d_ack   = 1'b1;
        d_rdata = 16'h0B0B;
        tick();
        chk("b2b_l2_wb", 32'(wb_valid), 32'h1);
        chk("b2b_l2_data", 32'(MemData_out), 32'h0B0B);
        chk("b2b_l2_rd", 32'(rd_out), 32'h3);
        ex_valid = 1'b0;
        d_ack    = 1'b0;
        tick();
        tick();
        chk("b2b_pulse_count", 32'(wb_pulses - pulse_base), 32'd3);
        chk("final_mem_err", 32'(mem_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
